// File: rtl/ctrl_multicycle_pkg.sv
// Shared types and encodings for the multicycle control unit.
// CTRL_BRANCH_EN adds beq support and the BRANCH state.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_WRITE = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC,
    MEM,
    WB
`ifdef CTRL_BRANCH_EN
    , BRANCH
`endif
  } state_e;

  typedef struct packed {
    logic rtype;
    logic load;
    logic store;
    logic addi;
    logic branch;
    logic illegal;
  } iclass_t;

endpackage

// File: rtl/ctrl_multicycle_if.sv
// Instruction handshake and datapath control bundle.
// slave = control unit, master = instruction source / datapath.
interface ctrl_multicycle_if #(
  parameter int RAW = 5
);
  logic [31:0]    instr;
  logic           instr_valid;
  logic           instr_ready;
  logic           Zero;
  logic [RAW-1:0] Read1;
  logic [RAW-1:0] Read2;
  logic [RAW-1:0] WriteReg;
  logic [1:0]     RegWrite;
  logic [3:0]     FuncCode;
  logic [1:0]     ALUOp;
  logic           mem_read;
  logic           mem_write;
  logic           branch_taken;
  logic           illegal;
  logic           done;

  modport master (
    output instr, instr_valid, Zero,
    input  instr_ready, Read1, Read2, WriteReg,
    input  RegWrite, FuncCode, ALUOp,
    input  mem_read, mem_write,
    input  branch_taken, illegal, done
  );

  modport slave (
    input  instr, instr_valid, Zero,
    output instr_ready, Read1, Read2, WriteReg,
    output RegWrite, FuncCode, ALUOp,
    output mem_read, mem_write,
    output branch_taken, illegal, done
  );
endinterface

// File: rtl/ctrl_multicycle_decode.sv
// Opcode to one-hot instruction class.
// beq decodes as illegal unless CTRL_BRANCH_EN is defined.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] op_i,
  output iclass_t        cls_o
);

  always_comb begin
    cls_o = '0;
    unique case (op_i)
      OPW'(OP_RTYPE): cls_o.rtype  = 1'b1;
      OPW'(OP_LW):    cls_o.load   = 1'b1;
      OPW'(OP_SW):    cls_o.store  = 1'b1;
      OPW'(OP_ADDI):  cls_o.addi   = 1'b1;
`ifdef CTRL_BRANCH_EN
      OPW'(OP_BEQ):   cls_o.branch = 1'b1;
`endif
      default:        cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_multicycle.sv
// Multicycle sequencer: IR capture, state machine, control decode.
// CTRL_BRANCH_EN enables beq via the BRANCH state.
module ctrl_multicycle
  import ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int RAW = 5
) (
  input  logic           clk,
  input  logic           reset,
  ctrl_multicycle_if.slave bus
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  iclass_t     cls;
  logic        accept;
  logic        exec_ph;
  logic        unused_ir;

  assign accept = bus.instr_valid & bus.instr_ready;
  assign unused_ir = ^{ir_q[10:4], bus.Zero};

  ctrl_decode #(.OPW(OPW)) u_dec (
    .op_i  (ir_q[31 -: OPW]),
    .cls_o (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = accept ? bus.instr : ir_q;
    unique case (state_q)
      IDLE:   if (accept) state_d = DECODE;
      DECODE: state_d = cls.illegal ? IDLE : EXEC;
      EXEC: begin
        unique case (1'b1)
          cls.rtype, cls.addi: state_d = WB;
          cls.load, cls.store: state_d = MEM;
`ifdef CTRL_BRANCH_EN
          cls.branch:          state_d = BRANCH;
`endif
          default:             state_d = IDLE;
        endcase
      end
      MEM:    state_d = cls.load ? WB : IDLE;
      WB:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALUOp/FuncCode stay put from EXEC until the instruction retires
  always_comb begin
    exec_ph = (state_q == EXEC) | (state_q == MEM) | (state_q == WB);
`ifdef CTRL_BRANCH_EN
    exec_ph = exec_ph | (state_q == BRANCH);
`endif
  end

  always_comb begin
    bus.instr_ready = (state_q == IDLE) & ~reset;
    bus.Read1       = ir_q[21 +: RAW];
    bus.Read2       = ir_q[16 +: RAW];
    bus.WriteReg    = '0;
    if (cls.rtype)
      bus.WriteReg = ir_q[11 +: RAW];
    else if (cls.load | cls.addi)
      bus.WriteReg = ir_q[16 +: RAW];

    bus.ALUOp = ALU_ADD;
    if (exec_ph & cls.rtype)
      bus.ALUOp = ALU_FUNC;
    else if (exec_ph & cls.branch)
      bus.ALUOp = ALU_SUB;
    bus.FuncCode = (exec_ph & cls.rtype) ? ir_q[3:0] : 4'b0000;

    // strobes are masked while reset is held so an abort never writes
    bus.RegWrite  = ((state_q == WB) & ~reset) ? RW_WRITE : RW_NONE;
    bus.mem_read  = (state_q == MEM) & cls.load & ~reset;
    bus.mem_write = (state_q == MEM) & cls.store & ~reset;
    bus.illegal   = (state_q == DECODE) & cls.illegal & ~reset;
    bus.done      = bus.illegal | bus.mem_write
                  | ((state_q == WB) & ~reset);
`ifdef CTRL_BRANCH_EN
    bus.branch_taken = (state_q == BRANCH) & bus.Zero & ~reset;
    bus.done = bus.done | ((state_q == BRANCH) & ~reset);
`else
    bus.branch_taken = 1'b0;
`endif
  end

endmodule

// File: tb/tb_ctrl_multicycle.sv
// Directed self-checking bench for ctrl_multicycle.
// beq checks follow CTRL_BRANCH_EN.
module tb_ctrl_multicycle;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  ctrl_multicycle_if #(.RAW(5)) bus ();

  ctrl_multicycle #(.OPW(6), .RAW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD  = {6'b000000, 5'd3, 5'd4, 5'd5, 5'd0, 6'b100000};
  localparam logic [31:0] I_SUB  = {6'b000000, 5'd10, 5'd11, 5'd12, 5'd0, 6'b100010};
  localparam logic [31:0] I_LW   = {6'b100011, 5'd1, 5'd2, 16'd4};
  localparam logic [31:0] I_SW   = {6'b101011, 5'd1, 5'd2, 16'd8};
  localparam logic [31:0] I_ADDI = {6'b001000, 5'd6, 5'd7, 16'd1};
  localparam logic [31:0] I_BEQ  = {6'b000100, 5'd8, 5'd9, 16'd2};
  localparam logic [31:0] I_BAD  = {6'b111111, 26'h155};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] w);
    bus.instr = w;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    bus.instr = 32'hFFFF_FFFF;
  endtask

  initial begin
    reset = 1'b1;
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    bus.Zero = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(bus.instr_ready), 0);
    chk("rst_regwr", 32'(bus.RegWrite), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_read1", 32'(bus.Read1), 0);
    chk("rst_aluop", 32'(bus.ALUOp), 0);
    reset = 1'b0;
    #1;
    chk("rst_ready_rel", 32'(bus.instr_ready), 1);

    // R-type add
    issue(I_ADD);
    chk("add_read1", 32'(bus.Read1), 3);
    chk("add_read2", 32'(bus.Read2), 4);
    chk("add_c1_done", 32'(bus.done), 0);
    chk("add_c1_ready", 32'(bus.instr_ready), 0);
    step();
    chk("add_c2_aluop", 32'(bus.ALUOp), 2);
    chk("add_c2_func", 32'(bus.FuncCode), 0);
    chk("add_c2_regwr", 32'(bus.RegWrite), 0);
    step();
    chk("add_c3_regwr", 32'(bus.RegWrite), 1);
    chk("add_c3_wreg", 32'(bus.WriteReg), 5);
    chk("add_c3_done", 32'(bus.done), 1);
    chk("add_c3_aluop", 32'(bus.ALUOp), 2);
    step();
    chk("add_c4_ready", 32'(bus.instr_ready), 1);
    chk("add_c4_done", 32'(bus.done), 0);

    // lw
    issue(I_LW);
    chk("lw_read1", 32'(bus.Read1), 1);
    step();
    chk("lw_c2_aluop", 32'(bus.ALUOp), 0);
    chk("lw_c2_mrd", 32'(bus.mem_read), 0);
    step();
    chk("lw_c3_mrd", 32'(bus.mem_read), 1);
    chk("lw_c3_done", 32'(bus.done), 0);
    chk("lw_c3_regwr", 32'(bus.RegWrite), 0);
    step();
    chk("lw_c4_regwr", 32'(bus.RegWrite), 1);
    chk("lw_c4_wreg", 32'(bus.WriteReg), 2);
    chk("lw_c4_done", 32'(bus.done), 1);
    chk("lw_c4_mrd", 32'(bus.mem_read), 0);
    step();
    chk("lw_c5_ready", 32'(bus.instr_ready), 1);

    // sw
    issue(I_SW);
    step();
    step();
    chk("sw_c3_mwr", 32'(bus.mem_write), 1);
    chk("sw_c3_done", 32'(bus.done), 1);
    chk("sw_c3_regwr", 32'(bus.RegWrite), 0);
    step();
    chk("sw_c4_ready", 32'(bus.instr_ready), 1);
    chk("sw_c4_mwr", 32'(bus.mem_write), 0);

`ifdef CTRL_BRANCH_EN
    bus.Zero = 1'b1;
    issue(I_BEQ);
    chk("beq1_c1_done", 32'(bus.done), 0);
    step();
    chk("beq1_c2_aluop", 32'(bus.ALUOp), 1);
    step();
    chk("beq1_c3_taken", 32'(bus.branch_taken), 1);
    chk("beq1_c3_done", 32'(bus.done), 1);
    chk("beq1_c3_aluop", 32'(bus.ALUOp), 1);
    step();
    chk("beq1_c4_ready", 32'(bus.instr_ready), 1);
    bus.Zero = 1'b0;
    issue(I_BEQ);
    step();
    chk("beq0_c2_aluop", 32'(bus.ALUOp), 1);
    step();
    chk("beq0_c3_taken", 32'(bus.branch_taken), 0);
    chk("beq0_c3_done", 32'(bus.done), 1);
    step();
`else
    bus.Zero = 1'b1;
    issue(I_BEQ);
    chk("beq_ill", 32'(bus.illegal), 1);
    chk("beq_done", 32'(bus.done), 1);
    chk("beq_taken", 32'(bus.branch_taken), 0);
    step();
    chk("beq_ready", 32'(bus.instr_ready), 1);
    bus.Zero = 1'b0;
`endif

    // unsupported opcode
    issue(I_BAD);
    chk("bad_ill", 32'(bus.illegal), 1);
    chk("bad_done", 32'(bus.done), 1);
    step();
    chk("bad_c2_ready", 32'(bus.instr_ready), 1);
    chk("bad_c2_ill", 32'(bus.illegal), 0);

    // reset while an R-type sits in EXEC
    issue(I_ADD);
    step();
    chk("abort_aluop", 32'(bus.ALUOp), 2);
    reset = 1'b1;
    #1;
    chk("abort_ready", 32'(bus.instr_ready), 0);
    step();
    chk("abort_regwr", 32'(bus.RegWrite), 0);
    chk("abort_read1", 32'(bus.Read1), 0);
    chk("abort_read2", 32'(bus.Read2), 0);
    chk("abort_wreg", 32'(bus.WriteReg), 0);
    chk("abort_aluop0", 32'(bus.ALUOp), 0);
    chk("abort_done", 32'(bus.done), 0);
    reset = 1'b0;
    #1;
    chk("abort_ready1", 32'(bus.instr_ready), 1);
    step();
    chk("abort_post_regwr", 32'(bus.RegWrite), 0);
    chk("abort_post_done", 32'(bus.done), 0);

    // valid held high, instr changing under a busy unit
    bus.instr = I_ADDI;
    bus.instr_valid = 1'b1;
    step();
    bus.instr = I_SUB;
    chk("b2b_a_read1", 32'(bus.Read1), 6);
    chk("b2b_a_ready", 32'(bus.instr_ready), 0);
    step();
    chk("b2b_a_aluop", 32'(bus.ALUOp), 0);
    chk("b2b_a_read1e", 32'(bus.Read1), 6);
    step();
    chk("b2b_a_wreg", 32'(bus.WriteReg), 7);
    chk("b2b_a_regwr", 32'(bus.RegWrite), 1);
    chk("b2b_a_done", 32'(bus.done), 1);
    step();
    chk("b2b_idle_ready", 32'(bus.instr_ready), 1);
    step();
    bus.instr_valid = 1'b0;
    bus.instr = I_LW;
    chk("b2b_b_read1", 32'(bus.Read1), 10);
    chk("b2b_b_read2", 32'(bus.Read2), 11);
    step();
    chk("b2b_b_aluop", 32'(bus.ALUOp), 2);
    chk("b2b_b_func", 32'(bus.FuncCode), 2);
    step();
    chk("b2b_b_wreg", 32'(bus.WriteReg), 12);
    chk("b2b_b_done", 32'(bus.done), 1);
    chk("b2b_b_func3", 32'(bus.FuncCode), 2);
    step();
    chk("b2b_end_ready", 32'(bus.instr_ready), 1);
    step();
    chk("b2b_end_idle", 32'(bus.instr_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_multicycle.md
# ctrl_multicycle

Multicycle instruction-sequencing control unit that drives the ALU/register-file datapath. Accepts one 32-bit MIPS-subset instruction per handshake, decodes it, and steps the datapath through decode, execute, memory and write-back cycles. Produces the register addresses, write enable, ALU function code and ALU operation the datapath consumes, and samples the datapath's `Zero` flag to resolve branches.

## Interface
- `OPW`, default 6: opcode field width (instr[31:26]).
- `RAW`, default 5: register address width.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset.
- `instr`  in  32: instruction word; sampled when `instr_valid & instr_ready`.
- `instr_valid`  in  1: instruction offered.
- `instr_ready`  out  1: unit idle, can accept.
- `Zero`  in  1: ALU zero flag from the datapath; sampled in BRANCH.
- `Read1`  out  RAW: rs (instr[25:21]).
- `Read2`  out  RAW: rt (instr[20:16]).
- `WriteReg`  out  RAW: rd (instr[15:11]) for R-type; rt for lw/addi.
- `RegWrite`  out  2: 2'b01 = write this cycle, 2'b00 = no write; bit 1 always 0.
- `FuncCode`  out  4: instr[3:0] for R-type; 4'b0000 otherwise.
- `ALUOp`  out  2: 00 add, 01 subtract, 10 use FuncCode.
- `mem_read` / `mem_write`  out  1 each: data-memory strobes.
- `branch_taken`  out  1: one-cycle pulse, beq resolved taken.
- `illegal`  out  1: one-cycle pulse, unsupported opcode.
- `done`  out  1: one-cycle pulse, instruction retired.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, addi 001000, beq 000100.
- Instruction register captures `instr` on accepted handshake; all field outputs derive from it, never from live `instr`.
- States: IDLE, DECODE, EXEC, MEM, WB, BRANCH.
- IDLE: `instr_ready`=1; on handshake -> DECODE. Otherwise stay.
- DECODE: Read1/Read2 valid. Illegal opcode -> `illegal`=1, `done`=1, -> IDLE. Else -> EXEC.
- EXEC: ALUOp driven (R-type 10, lw/sw/addi 00, beq 01). R-type/addi -> WB; lw/sw -> MEM; beq -> BRANCH.
- MEM: lw: `mem_read`=1, -> WB. sw: `mem_write`=1, `done`=1, -> IDLE.
- WB: `RegWrite`=2'b01, `done`=1, -> IDLE. WriteReg = 0 still writes (suppression is the register file's job).
- BRANCH: ALUOp held 01; `branch_taken`=`Zero`; `done`=1, -> IDLE.
- ALUOp and FuncCode held stable from EXEC through the retiring state.

## Timing
- Handshake edge = cycle 0. Retire (`done`) at: illegal cycle 1, R-type/addi cycle 3, sw cycle 3, lw cycle 4, beq cycle 3. `instr_ready` high again the cycle after `done`.
- `instr_ready` combinational from state; `instr_valid` without `instr_ready` is ignored, not queued.
- All other outputs registered/state-decoded, glitch-free, single-cycle pulses.
- Reset (any state, mid-instruction included): next edge -> IDLE, instruction register cleared; `instr_ready`=0 while `reset`=1. Reset values: Read1/Read2/WriteReg 0, RegWrite 2'b00, FuncCode 0, ALUOp 00, mem_read/mem_write/branch_taken/illegal/done 0. No write or memory strobe issued for an aborted instruction.

## Configuration
- `CTRL_BRANCH_EN` defined: beq supported as above.
- Undefined: BRANCH state absent; opcode 000100 decodes illegal (`illegal` pulse at cycle 1); `branch_taken` tied 0.

## Structure
- Shared package `ctrl_pkg`: opcode constants, ALUOp encodings (ALU_ADD, ALU_SUB, ALU_FUNC), state enum typedef, RegWrite encodings.
- One sub-module `ctrl_decode`: combinational opcode -> instruction class (rtype, load, store, addi, branch, illegal). FSM and instruction register stay in top.

## Test plan
- Reset mid-EXEC of R-type -> IDLE next edge; all outputs at reset values; no RegWrite pulse.
- R-type add rs=3, rt=4, rd=5, funct 100000 -> Read1=3, Read2=4, ALUOp=10, FuncCode=0000, cycle 3: RegWrite=01, WriteReg=5, done=1.
- lw rs=1, rt=2 -> ALUOp=00, cycle 3 mem_read=1, cycle 4 RegWrite=01, WriteReg=2, done; sw -> mem_write and done at cycle 3, no RegWrite.
- beq with Zero=1 then Zero=0 -> ALUOp=01; branch_taken=1 / 0 at cycle 3; with `CTRL_BRANCH_EN` undefined -> illegal=1 at cycle 1.
- Opcode 111111 -> illegal=1, done=1 at cycle 1; instr_ready=1 at cycle 2.
- instr_valid held high continuously with changing instr -> one instruction accepted per IDLE visit; outputs follow captured word only.
